// File: rtl/store_buffer.sv
// Post-commit store queue: accepts retired stores, drains them in order to the
// D-cache over req/ack, and forwards the youngest matching store to loads.
module store_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     rob_commitmemwrite,
    input  logic [AW-1:0]            rob_swaddr,
    input  logic [DW-1:0]            rob_swdata,
    output logic                     sb_full,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count,
    output logic                     sb_dc_req,
    output logic [AW-1:0]            sb_dc_addr,
    output logic [DW-1:0]            sb_dc_data,
    input  logic                     dc_sb_ack,
    input  logic                     ld_chk_val,
    input  logic [AW-1:0]            ld_chk_addr,
    output logic                     sb_ld_hit,
    output logic [DW-1:0]            sb_ld_data
);

    // state | meaning
    // IDLE  | no drain request outstanding
    // REQ   | head entry presented to the D-cache, waiting for ack

    localparam int LW = $clog2(DEPTH);
    localparam int PW = LW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  count_nxt;
    logic [AW-1:0]  mem_addr [DEPTH];
    logic [DW-1:0]  mem_data [DEPTH];
    logic           push;
    logic           pop;
    logic [LW-1:0]  fwd_idx;
    logic           unused_byte_bits;

    // Status decodes only the registered pointers, keeping sb_full free of
    // combinational paths from push or ack.
    assign sb_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]);
    assign sb_empty = (wr_ptr == rd_ptr);
    assign sb_count = wr_ptr - rd_ptr;

    assign push      = rob_commitmemwrite & ~sb_full;
    assign pop       = (state == REQ) & dc_sb_ack;
    assign count_nxt = sb_count + PW'(push) - PW'(pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            state <= state_nxt;
        end
    end

    // Entry payload needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[LW-1:0]] <= rob_swaddr;
            mem_data[wr_ptr[LW-1:0]] <= rob_swdata;
        end
    end

    always_comb begin
        state_nxt = state;
        sb_dc_req = 1'b0;
        case (state)
            IDLE: begin
                if (count_nxt != '0) state_nxt = REQ;
            end
            REQ: begin
                sb_dc_req = 1'b1;
                if (pop && (count_nxt == '0)) state_nxt = IDLE;
            end
        endcase
    end

    assign sb_dc_addr = sb_empty ? '0 : mem_addr[rd_ptr[LW-1:0]];
    assign sb_dc_data = sb_empty ? '0 : mem_data[rd_ptr[LW-1:0]];

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        sb_ld_hit  = 1'b0;
        sb_ld_data = '0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr[LW-1:0] + LW'(k);
            if (ld_chk_val && (PW'(k) < sb_count) &&
                (mem_addr[fwd_idx][AW-1:2] == ld_chk_addr[AW-1:2])) begin
                sb_ld_hit  = 1'b1;
                sb_ld_data = mem_data[fwd_idx];
            end
        end
    end

    // Word granularity: the byte offset of a load never affects matching.
    assign unused_byte_bits = ^ld_chk_addr[1:0];

endmodule
